// File: rtl/bcd_entry_pkg.sv
// Shared types and nibble helpers for the BCD operand-entry block.
// Helpers work on a MAX_DIGITS-wide nibble vector; callers keep the low 4*DIGITS bits.
package bcd_entry_pkg;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2,
    SHOWN = 2'd3
  } entry_state_e;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         MAX_DIGITS = 16;
  localparam int         MAX_W      = 4*MAX_DIGITS;

  function automatic logic [MAX_W-1:0] nib_shl_ins(input logic [MAX_W-1:0] v,
                                                   input logic [3:0]       d);
    return {v[MAX_W-5:0], d};
  endfunction

  function automatic logic [MAX_W-1:0] nib_shr(input logic [MAX_W-1:0] v);
    return {4'd0, v[MAX_W-1:4]};
  endfunction
endpackage

// File: rtl/bcd_operand_entry_if.sv
// Keypad/memory control bundle and operand status for bcd_operand_entry.
interface bcd_operand_entry_if #(parameter int DIGITS = 3);
  localparam int W  = 4*DIGITS+1;
  localparam int CW = $clog2(DIGITS+1);

  logic          digit_valid;
  logic [3:0]    digit;
  logic          clear;
  logic          backspace;
  logic          recall;
  logic          mem_store;
  logic [W-1:0]  mem_data;
  logic          sign_load;
  logic          sign_in;
  logic [W-1:0]  value;
  logic [CW-1:0] digit_count;
  logic          full;
  logic          overflow;
  logic          invalid;
  logic [1:0]    state;

  modport master (
    output digit_valid, digit, clear, backspace, recall, mem_store, mem_data,
           sign_load, sign_in,
    input  value, digit_count, full, overflow, invalid, state
  );

  modport slave (
    input  digit_valid, digit, clear, backspace, recall, mem_store, mem_data,
           sign_load, sign_in,
    output value, digit_count, full, overflow, invalid, state
  );
endinterface

// File: rtl/bcd_digit_shifter.sv
// Combinational shift-left-insert and shift-right candidates for the operand magnitude.
module bcd_digit_shifter
  import bcd_entry_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic [4*DIGITS-1:0] mag,
  input  logic [3:0]          digit,
  output logic [4*DIGITS-1:0] shl,
  output logic [4*DIGITS-1:0] shr
);
  logic [MAX_W-1:0] ext, shl_w, shr_w;

  assign ext   = MAX_W'(mag);
  assign shl_w = nib_shl_ins(ext, digit);
  assign shr_w = nib_shr(ext);
  assign shl   = shl_w[4*DIGITS-1:0];
  assign shr   = shr_w[4*DIGITS-1:0];

  // Bits above the operand width fall off the shift and are discarded.
  if (DIGITS < MAX_DIGITS) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^{shl_w[MAX_W-1:4*DIGITS], shr_w[MAX_W-1:4*DIGITS]};
  end
endmodule

// File: rtl/bcd_operand_entry.sv
// Signed BCD operand-entry register with digit count, overflow/invalid pulses and entry FSM.
// Define BCD_ENTRY_MEM_EN for an internal memory slot; otherwise recall reads mem_data.
module bcd_operand_entry
  import bcd_entry_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  bcd_operand_entry_if.slave  bus
);
  localparam int              W       = 4*DIGITS+1;
  localparam int              CW      = $clog2(DIGITS+1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DIGITS);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  logic [W-1:0]        val_q, val_d, mem_src;
  logic [CW-1:0]       cnt_q, cnt_d, bs_cnt;
  entry_state_e        st_q, st_d;
  logic                ovf_q, ovf_d, inv_q, inv_d;
  logic [4*DIGITS-1:0] shl, shr, dig_only;

  bcd_digit_shifter #(.DIGITS(DIGITS)) u_shift (
    .mag   (val_q[W-2:0]),
    .digit (bus.digit),
    .shl   (shl),
    .shr   (shr)
  );

`ifdef BCD_ENTRY_MEM_EN
  logic [W-1:0] mem_q;
  logic         unused_mem;

  // Stores the pre-update value, so store+clear in one cycle keeps the old operand.
  always_ff @(posedge clk or negedge reset)
    if (!reset)             mem_q <= '0;
    else if (bus.mem_store) mem_q <= val_q;

  assign mem_src    = mem_q;
  assign unused_mem = ^bus.mem_data;
`else
  logic unused_mem;
  assign mem_src    = bus.mem_data;
  assign unused_mem = bus.mem_store;
`endif

  always_comb begin
    val_d    = val_q;
    cnt_d    = cnt_q;
    st_d     = st_q;
    ovf_d    = 1'b0;
    inv_d    = 1'b0;
    bs_cnt   = (st_q == SHOWN) ? CNT_MAX : cnt_q;
    dig_only = '0;
    dig_only[3:0] = bus.digit;

    if (bus.clear) begin
      val_d = {bus.sign_in, {(W-1){1'b0}}};
      cnt_d = '0;
      st_d  = EMPTY;
    end else if (bus.recall) begin
      val_d = mem_src;
      cnt_d = CNT_MAX;
      st_d  = SHOWN;
    end else if (bus.backspace) begin
      if (st_q != EMPTY) begin
        val_d = {val_q[W-1], shr};
        cnt_d = bs_cnt - CNT_ONE;
        st_d  = (bs_cnt == CNT_ONE) ? EMPTY : ENTRY;
      end
    end else if (bus.digit_valid) begin
      if (bus.digit > BCD_MAX) begin
        inv_d = 1'b1;
      end else begin
        case (st_q)
          EMPTY, ENTRY: begin
            val_d = {val_q[W-1], shl};
            cnt_d = cnt_q + CNT_ONE;
            st_d  = (cnt_q == CNT_MAX - CNT_ONE) ? FULL : ENTRY;
          end
          FULL: ovf_d = 1'b1;
          SHOWN: begin
            // A keypress after recall starts a fresh number rather than appending.
            val_d = {val_q[W-1], dig_only};
            cnt_d = CNT_ONE;
            st_d  = (DIGITS == 1) ? FULL : ENTRY;
          end
          default: st_d = EMPTY;
        endcase
      end
    end else if (bus.sign_load) begin
      val_d[W-1] = bus.sign_in;
    end
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      val_q <= '0;
      cnt_q <= '0;
      st_q  <= EMPTY;
      ovf_q <= 1'b0;
      inv_q <= 1'b0;
    end else begin
      val_q <= val_d;
      cnt_q <= cnt_d;
      st_q  <= st_d;
      ovf_q <= ovf_d;
      inv_q <= inv_d;
    end

  assign bus.value       = val_q;
  assign bus.digit_count = cnt_q;
  assign bus.full        = (cnt_q == CNT_MAX);
  assign bus.overflow    = ovf_q;
  assign bus.invalid     = inv_q;
  assign bus.state       = st_q;
endmodule

// File: tb/tb_bcd_operand_entry.sv
// Directed-vector bench for bcd_operand_entry (DIGITS=3); valid with or without BCD_ENTRY_MEM_EN.
module tb_bcd_operand_entry;
  import bcd_entry_pkg::*;

  localparam int DIGITS = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  bcd_operand_entry_if #(.DIGITS(DIGITS)) bus ();

  bcd_operand_entry #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic drop_pulses();
    bus.digit_valid = 1'b0;
    bus.clear       = 1'b0;
    bus.backspace   = 1'b0;
    bus.recall      = 1'b0;
    bus.mem_store   = 1'b0;
    bus.sign_load   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drop_pulses();
  endtask

  task automatic key(input logic [3:0] d);
    bus.digit_valid = 1'b1;
    bus.digit       = d;
    tick();
  endtask

  task automatic expect_st(input string tag, input logic [12:0] val, input int cnt,
                           input entry_state_e st, input logic ov, input logic inv);
    chk({tag, ".value"}, bus.value, val);
    chk({tag, ".count"}, bus.digit_count, cnt);
    chk({tag, ".full"},  bus.full, (cnt == DIGITS));
    chk({tag, ".state"}, bus.state, st);
    chk({tag, ".ovf"},   bus.overflow, ov);
    chk({tag, ".inv"},   bus.invalid, inv);
  endtask

  initial begin
    drop_pulses();
    bus.digit    = 4'd0;
    bus.mem_data = '0;
    bus.sign_in  = 1'b0;
    #1 reset = 1'b0;
    #2 expect_st("reset", 13'h0000, 0, EMPTY, 0, 0);
    #9 reset = 1'b1;

    key(4'd1); expect_st("d1", 13'h0001, 1, ENTRY, 0, 0);
    key(4'd2); expect_st("d2", 13'h0012, 2, ENTRY, 0, 0);
    key(4'd3); expect_st("d3", 13'h0123, 3, FULL,  0, 0);
    key(4'd7); expect_st("d4_ovf", 13'h0123, 3, FULL, 1, 0);
    tick();    expect_st("ovf_drop", 13'h0123, 3, FULL, 0, 0);
    key(4'hF); expect_st("full_bad", 13'h0123, 3, FULL, 0, 1);

    bus.backspace = 1'b1; tick(); expect_st("bs1", 13'h0012, 2, ENTRY, 0, 0);
    bus.backspace = 1'b1; tick(); expect_st("bs2", 13'h0001, 1, ENTRY, 0, 0);
    bus.backspace = 1'b1; tick(); expect_st("bs3", 13'h0000, 0, EMPTY, 0, 0);
    bus.backspace = 1'b1; tick(); expect_st("bs4", 13'h0000, 0, EMPTY, 0, 0);

    key(4'd0); expect_st("lead0", 13'h0000, 1, ENTRY, 0, 0);
    key(4'd4); expect_st("d4", 13'h0004, 2, ENTRY, 0, 0);
    key(4'hA); expect_st("badA", 13'h0004, 2, ENTRY, 0, 1);
    tick();    expect_st("inv_drop", 13'h0004, 2, ENTRY, 0, 0);
    key(4'd5); expect_st("d5", 13'h0045, 3, FULL, 0, 0);

    // Build 0x1456, store it while clearing, then recall.
    bus.sign_in = 1'b1; bus.clear = 1'b1; tick();
    expect_st("clr_neg", 13'h1000, 0, EMPTY, 0, 0);
    key(4'd4); key(4'd5); key(4'd6);
    expect_st("neg456", 13'h1456, 3, FULL, 0, 0);
    bus.mem_data = 13'h1456; bus.mem_store = 1'b1;
    bus.sign_in = 1'b0; bus.clear = 1'b1; tick();
    expect_st("st_clr", 13'h0000, 0, EMPTY, 0, 0);
    bus.recall = 1'b1; tick(); expect_st("rcl", 13'h1456, 3, SHOWN, 0, 0);
    key(4'd8);                 expect_st("rcl_d8", 13'h1008, 1, ENTRY, 0, 0);
    bus.recall = 1'b1; tick(); expect_st("rcl2", 13'h1456, 3, SHOWN, 0, 0);
    bus.backspace = 1'b1; bus.digit_valid = 1'b1; bus.digit = 4'd2; tick();
    expect_st("shown_bs", 13'h1045, 2, ENTRY, 0, 0);
    bus.sign_load = 1'b1; tick(); expect_st("sgn0", 13'h0045, 2, ENTRY, 0, 0);

    bus.sign_in = 1'b1; bus.clear = 1'b1; bus.recall = 1'b1;
    bus.digit_valid = 1'b1; bus.digit = 4'd9; tick();
    expect_st("prio_clr", 13'h1000, 0, EMPTY, 0, 0);
    bus.recall = 1'b1; bus.backspace = 1'b1; bus.sign_load = 1'b1; bus.sign_in = 1'b0; tick();
    expect_st("prio_rcl", 13'h1456, 3, SHOWN, 0, 0);
    bus.clear = 1'b1; tick(); expect_st("clr_pos", 13'h0000, 0, EMPTY, 0, 0);

    // Asynchronous reset between clock edges.
    key(4'd1); key(4'd2); expect_st("pre_rst", 13'h0012, 2, ENTRY, 0, 0);
    #3 reset = 1'b0;
    #1 expect_st("async_rst", 13'h0000, 0, EMPTY, 0, 0);
    #2 reset = 1'b1;
    tick(); expect_st("post_rst", 13'h0000, 0, EMPTY, 0, 0);

    key(4'd9); key(4'd8); key(4'd7);
    expect_st("e987", 13'h0987, 3, FULL, 0, 0);
    bus.mem_data = 13'h0987; bus.mem_store = 1'b1; bus.clear = 1'b1; tick();
    expect_st("st987", 13'h0000, 0, EMPTY, 0, 0);
    bus.recall = 1'b1; tick(); expect_st("rt987", 13'h0987, 3, SHOWN, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bcd_operand_entry.md
Name: bcd_operand_entry

Overview:
- Parametrised successor to the calculator's operand-entry register. It accumulates keypad BCD digits into a signed DIGITS-wide BCD operand and applies sign, clear, backspace and memory recall.
- Adds digit counting, full/overflow detection, invalid-digit rejection and an entry state machine that replaces a recalled value on the next keypress.
- Sits between the keypad decoder / memory unit and the ALU operand registers A/B.

Parameters:
- DIGITS, 3, number of BCD digits held (≥1)
- W, 4*DIGITS+1, operand width: sign bit MSB, then DIGITS nibbles, most significant digit first (derived; do not override)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- digit_valid  in  1  one-cycle pulse: keypad digit present
- digit  in  4  BCD digit value
- clear  in  1  pulse: zero the operand, sign forced to sign_in
- backspace  in  1  pulse: drop the least significant digit
- recall  in  1  pulse: load mem_data into the operand
- mem_store  in  1  pulse: capture the operand into memory (MEM_EN build only)
- mem_data  in  W  external memory value (non-MEM_EN build)
- sign_load  in  1  pulse: write sign_in into the sign bit
- sign_in  in  1  sign source (negative flag for operand A or B, selected upstream)
- value  out  W  current operand
- digit_count  out  $clog2(DIGITS+1)  digits entered
- full  out  1  digit_count == DIGITS
- overflow  out  1  one-cycle pulse: digit rejected because full
- invalid  out  1  one-cycle pulse: digit > 9 rejected
- state  out  2  FSM state code

Behaviour:
- Reset (async, reset low): value=0, digit_count=0, state=EMPTY, overflow=0, invalid=0; memory slot=0 in MEM_EN build.
- All updates take effect on the rising clk edge; outputs are registered, latency 1 cycle.
- Priority when pulses coincide: clear > recall > backspace > digit_valid > sign_load. Exactly one action per cycle; lower-priority pulses are dropped with no side effect. mem_store is independent and samples value before that cycle's update.
- States: EMPTY=0, ENTRY=1, FULL=2, SHOWN=3.
- clear, any state: value={sign_in, 0}, count=0, -> EMPTY.
- recall, any state: value=memory, count=DIGITS, -> SHOWN.
- digit_valid with digit>9: nothing changes; invalid pulses 1 cycle. Checked before the state rules.
- digit_valid, EMPTY or ENTRY: nibbles shift left one place, new digit enters the LSB nibble, sign kept, count+1. -> FULL if count reaches DIGITS, else ENTRY.
- digit_valid, FULL: value unchanged; overflow pulses 1 cycle.
- digit_valid, SHOWN: value={sign kept, 0…0, digit}, count=1, -> ENTRY (or FULL when DIGITS=1).
- backspace, ENTRY or FULL: nibbles shift right one place, zero enters the MSB nibble, count-1. -> EMPTY if count reaches 0, else ENTRY.
- backspace, SHOWN: treated as ENTRY with count=DIGITS.
- backspace, EMPTY: no-op.
- Leading zeros count as digits: entering 0 in EMPTY gives count=1.
- sign_load, any state: value[W-1]=sign_in, all else unchanged.
- overflow and invalid are never high together and never high for two consecutive cycles unless triggered again.
- Reset asserted mid-entry: immediate return to the reset values, independent of clk.

Optional Feature:
- BCD_ENTRY_MEM_EN defined: internal W-bit memory slot. mem_store writes value into it; recall reads it; mem_data is ignored.
- BCD_ENTRY_MEM_EN undefined: no storage. recall reads mem_data; mem_store is ignored.

Decomposition:
- Package bcd_entry_pkg holds the state enum (EMPTY/ENTRY/FULL/SHOWN), the BCD_MAX=9 constant and helper functions for nibble shift-left-insert and shift-right.
- One natural sub-module: bcd_digit_shifter (combinational, parametrised by DIGITS, produces the shifted-left and shifted-right candidates).
- Control logic and FSM stay in the top level.

Test Plan (DIGITS=3):
- Reset, enter digits 1,2,3 -> value=0x0123 (13-bit), count=3, full=1, state=FULL; a 4th digit 7 -> value unchanged, overflow high for exactly 1 cycle.
- From 0x0123, backspace twice -> 0x0012 then 0x0001; a third backspace -> 0x0000, EMPTY; a fourth -> no change.
- digit 0xA in ENTRY -> invalid pulse, value/count unchanged; next digit 5 accepted normally.
- recall with memory=0x1456 -> value=0x1456, SHOWN; then digit 8 -> value=0x1008, count=1, ENTRY.
- clear, recall and digit_valid in the same cycle with sign_in=1 -> value=0x1000, EMPTY, no overflow or invalid pulse.
- Mid-entry (value=0x0012), assert reset between clock edges -> value=0 immediately. Run with BCD_ENTRY_MEM_EN both defined and undefined: mem_store then recall round-trips 0x0987.
